seq_mult_acc: RTL and testbench

Parametrised sequential multiply–accumulate unit, the successor to the fixed 4×4 combinational array multiplier. It retires DIGIT multiplier bits per cycle through a small array row, which trades latency for area on the TinyTapeout tile. It supports signed and unsigned operands and an optional running accumulator. Operands enter on a valid/ready handshake and results leave on one. The block sits between the nibble-serial operand loader and the PCPI-style coprocessor result path.

---
 rtl/mult_pkg.sv | 18 +
 rtl/full_adder.sv | 13 +
 rtl/seq_mult_acc_pp_row_adder.sv | 46 ++++
 rtl/seq_mult_acc.sv | 116 +++++++++++
 tb/tb_seq_mult_acc.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the sequential multiply-accumulate unit.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit cfg_ok(input int width, input int digit);
    return (digit == 1 || digit == 2 || digit == 4) && (width >= 2) && (width % digit == 0);
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/seq_mult_acc_pp_row_adder.sv
// Adds WIDTH x DIGIT partial products, placed at bit DIGIT*cnt, into a 2*WIDTH sum.
// Combinational, no handshake; one ripple chain of full adders per multiplier bit.
module pp_row_adder
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2,
  parameter int CW    = cnt_width(WIDTH / DIGIT)
) (
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [DIGIT-1:0]   b_dig,
  input  logic [CW-1:0]      cnt,
  input  logic [2*WIDTH-1:0] sum_in,
  output logic [2*WIDTH-1:0] sum_out
);

  localparam int W2 = 2 * WIDTH;

  logic [DIGIT:0][W2-1:0]   stage;
  logic [DIGIT-1:0][W2-1:0] row;

  assign stage[0] = sum_in;

  for (genvar j = 0; j < DIGIT; j++) begin : g_row
    logic [W2-1:0] cy;

    assign row[j] = {{WIDTH{1'b0}}, a_mag & {WIDTH{b_dig[j]}}} << (DIGIT * int'(cnt) + j);
    assign cy[0]  = 1'b0;

    for (genvar k = 0; k < W2 - 1; k++) begin : g_bit
      full_adder u_fa (
        .a  (stage[j][k]),
        .b  (row[j][k]),
        .ci (cy[k]),
        .s  (stage[j+1][k]),
        .co (cy[k+1])
      );
    end

    // The full product never exceeds 2*WIDTH bits, so the top carry-out is not needed.
    assign stage[j+1][W2-1] = stage[j][W2-1] ^ row[j][W2-1] ^ cy[W2-1];
  end

  assign sum_out = stage[DIGIT];

endmodule

// File: rtl/seq_mult_acc.sv
// Sequential signed/unsigned multiply-accumulate retiring DIGIT multiplier bits per cycle.
// Result is valid WIDTH/DIGIT edges after accept; it holds in DONE until out_ready, in_ready is low meanwhile.
module seq_mult_acc
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  input  logic               accumulate,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam int W2 = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!cfg_ok(WIDTH, DIGIT)) begin : g_cfg_err
    $error("seq_mult_acc: DIGIT must be 1, 2 or 4 and divide WIDTH");
  end

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] a_mag, b_sh;
  logic            neg, acc_op, sgn_op;
  logic [W2-1:0]   partial, partial_nxt, acc, result_q, prod, sum;
  logic            ovf_q, carry, ovf_nxt, accept;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)     state_nxt = BUSY;
      BUSY:    if (cnt == LAST)  state_nxt = DONE;
      DONE:    if (out_ready)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = (state == IDLE) && in_valid;
  assign result    = result_q;
  assign overflow  = ovf_q;

  pp_row_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT), .CW(CW)) u_row (
    .a_mag   (a_mag),
    .b_dig   (b_sh[DIGIT-1:0]),
    .cnt     (cnt),
    .sum_in  (partial),
    .sum_out (partial_nxt)
  );

  // Finalisation on the last BUSY edge: restore sign, then optional accumulate.
  always_comb begin
    prod         = neg ? -partial_nxt : partial_nxt;
    {carry, sum} = {1'b0, acc} + {1'b0, prod};
    ovf_nxt      = 1'b0;
    if (acc_op) begin
      ovf_nxt = sgn_op ? ((acc[W2-1] == prod[W2-1]) && (sum[W2-1] != acc[W2-1])) : carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_mag    <= '0;
      b_sh     <= '0;
      neg      <= 1'b0;
      acc_op   <= 1'b0;
      sgn_op   <= 1'b0;
      partial  <= '0;
      acc      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      // A clear coinciding with accept lands before the operation's add.
      if (state == IDLE && acc_clr) acc <= '0;
      if (accept) begin
        a_mag   <= mag(a, is_signed);
        b_sh    <= mag(b, is_signed);
        neg     <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        acc_op  <= accumulate;
        sgn_op  <= is_signed;
        partial <= '0;
        cnt     <= '0;
      end else if (state == BUSY) begin
        partial <= partial_nxt;
        cnt     <= cnt + CW'(1);
        b_sh    <= b_sh >> DIGIT;
        if (cnt == LAST) begin
          result_q <= acc_op ? sum : prod;
          acc      <= acc_op ? sum : prod;
          ovf_q    <= ovf_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_acc.sv
// Self-checking bench for seq_mult_acc (WIDTH=8, DIGIT=2) against an arithmetic reference model.
module tb_seq_mult_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  a = '0, b = '0;
  logic        is_signed = 1'b0, accumulate = 1'b0, acc_clr = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [15:0] result;
  logic        overflow;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] acc_m = '0;

  seq_mult_acc #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .accumulate(accumulate), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer product reduced mod 2^16, then the accumulate add.
  task automatic model(input logic [7:0] av, input logic [7:0] bv, input logic sg, input logic ac,
                       output logic [15:0] r, output logic ov);
    longint p, s;
    logic [15:0] pm;
    if (sg) p = longint'($signed(av)) * longint'($signed(bv));
    else    p = longint'(av) * longint'(bv);
    pm = 16'(p);
    ov = 1'b0;
    if (ac) begin
      if (sg) begin
        s  = longint'($signed(acc_m)) + longint'($signed(pm));
        ov = (s > 32767) || (s < -32768);
      end else begin
        s  = longint'(acc_m) + longint'(pm);
        ov = (s > 65535);
      end
      r = 16'(s);
    end else begin
      r = pm;
    end
    acc_m = r;
  endtask

  task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic sg, input logic ac, input logic cl);
    int t;
    t = 0;
    a = av; b = bv; is_signed = sg; accumulate = ac; acc_clr = cl; in_valid = 1'b1;
    while (!in_ready && t < 100) begin cyc(); t++; end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: in_ready=%b, required 1", in_ready);
    end
    cyc();
    in_valid = 1'b0; acc_clr = 1'b0;
  endtask

  task automatic collect(input bit scramble, output logic [15:0] r, output logic ov, output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (scramble) begin
        a = 8'($urandom); b = 8'($urandom); is_signed = 1'($urandom);
        accumulate = 1'($urandom); acc_clr = 1'($urandom);
      end
      cyc(); lat++;
    end
    if (!out_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL collect_timeout: out_valid=%b, required 1", out_valid);
    end
    r = result; ov = overflow;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0; acc_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    acc_m = '0;
    cyc();
    n_cmp++; if (in_ready !== 1'b1)   begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== 16'h0)    begin n_bad++; $display("FAIL reset_result: got %h want 0000", result); end
    n_cmp++; if (overflow !== 1'b0)   begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_unsigned();
    logic [15:0] r, er; logic ov, eo; int lat;
    issue(8'd13, 8'd11, 1'b0, 1'b0, 1'b0);
    model(8'd13, 8'd11, 1'b0, 1'b0, er, eo);
    collect(1'b0, r, ov, lat);
    n_cmp++; if (r !== 16'h008F) begin n_bad++; $display("FAIL unsigned_13x11: got %h want 008f", r); end
    n_cmp++; if (ov !== 1'b0)    begin n_bad++; $display("FAIL unsigned_ovf: got %b want 0", ov); end
    n_cmp++; if (lat != 5)       begin n_bad++; $display("FAIL unsigned_latency: got %0d want 5", lat); end
    consume();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_bad++; $display("FAIL unsigned_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_signed();
    logic [15:0] r, er; logic ov, eo; int lat;
    issue(8'hFD, 8'h05, 1'b1, 1'b0, 1'b0);
    model(8'hFD, 8'h05, 1'b1, 1'b0, er, eo);
    collect(1'b0, r, ov, lat);
    consume();
    n_cmp++; if (r !== 16'hFFF1) begin n_bad++; $display("FAIL signed_m3x5: got %h want fff1", r); end
    issue(8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
    model(8'h80, 8'h80, 1'b1, 1'b0, er, eo);
    collect(1'b0, r, ov, lat);
    consume();
    n_cmp++; if (r !== 16'h4000 || ov !== 1'b0)
      begin n_bad++; $display("FAIL signed_min_sq: got %h/%b want 4000/0", r, ov); end
  endtask

  task automatic test_accumulate();
    logic [15:0] r, er; logic ov, eo; int lat;
    logic [15:0] exp_r [5] = '{16'h9C40, 16'h3880, 16'h3F01, 16'h7E02, 16'hBD03};
    logic        exp_o [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      logic [7:0] v; logic sg, cl;
      v  = (i < 2) ? 8'd200 : 8'h7F;
      sg = (i >= 2);
      cl = (i == 0 || i == 2);
      if (cl) acc_m = '0;
      issue(v, v, sg, 1'b1, cl);
      model(v, v, sg, 1'b1, er, eo);
      acc_clr = 1'b1;
      collect(1'b0, r, ov, lat);
      consume();
      n_cmp++; if (r !== exp_r[i] || ov !== exp_o[i])
        begin n_bad++; $display("FAIL accumulate_%0d: got %h/%b want %h/%b", i, r, ov, exp_r[i], exp_o[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] r0, r, er; logic ov0, ov, eo; int lat;
    issue(8'h25, 8'h3C, 1'b0, 1'b0, 1'b0);
    model(8'h25, 8'h3C, 1'b0, 1'b0, er, eo);
    collect(1'b0, r0, ov0, lat);
    n_cmp++; if (r0 !== 16'h08AC) begin n_bad++; $display("FAIL bp_result: got %h want 08ac", r0); end
    a = 8'h11; b = 8'h22; is_signed = 1'b0; accumulate = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_cmp++; if (result !== r0 || overflow !== ov0 || out_valid !== 1'b1 || in_ready !== 1'b0)
        begin n_bad++; $display("FAIL bp_hold_%0d: got %h/%b ov=%b ir=%b want %h/%b 1 0",
                                i, result, overflow, out_valid, in_ready, r0, ov0); end
    end
    consume();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after: got %b want 1", in_ready); end
    cyc();
    in_valid = 1'b0;
    model(8'h11, 8'h22, 1'b0, 1'b0, er, eo);
    collect(1'b0, r, ov, lat);
    consume();
    n_cmp++; if (r !== 16'h0242 || lat != 5)
      begin n_bad++; $display("FAIL bp_pending_op: got %h lat %0d want 0242 lat 5", r, lat); end
  endtask

  task automatic test_reset_midbusy();
    logic [15:0] r, er; logic ov, eo; int lat;
    issue(8'h0F, 8'h0F, 1'b0, 1'b1, 1'b0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    acc_m = '0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin n_bad++; $display("FAIL midbusy_state: ir=%b ov=%b want 1/0", in_ready, out_valid); end
    issue(8'd7, 8'd9, 1'b0, 1'b1, 1'b0);
    model(8'd7, 8'd9, 1'b0, 1'b1, er, eo);
    collect(1'b0, r, ov, lat);
    consume();
    n_cmp++; if (r !== 16'h003F || ov !== 1'b0 || lat != 5)
      begin n_bad++; $display("FAIL midbusy_7x9: got %h/%b lat %0d want 003f/0 lat 5", r, ov, lat); end
  endtask

  task automatic test_sweep();
    logic [15:0] r, er; logic ov, eo; int lat, hold;
    logic [7:0] av, bv; logic sg, ac, cl;
    logic [7:0] corner [7] = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h01, 8'h81, 8'h40};
    for (int i = 0; i < 2000; i++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        acc_clr = ($urandom_range(0, 7) == 0);
        if (acc_clr) acc_m = '0;
        cyc();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL sweep_dup_%0d: out_valid=%b want 0", i, out_valid); end
        acc_clr = 1'b0;
      end
      if (i < 98) begin av = corner[(i / 14) % 7]; bv = corner[(i / 2) % 7]; sg = i[0]; end
      else begin av = 8'($urandom); bv = 8'($urandom); sg = 1'($urandom); end
      ac = 1'($urandom);
      cl = ($urandom_range(0, 7) == 0);
      if (cl) acc_m = '0;
      issue(av, bv, sg, ac, cl);
      model(av, bv, sg, ac, er, eo);
      collect(1'b1, r, ov, lat);
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) cyc();
      consume();
      n_cmp++; if (r !== er || ov !== eo || lat != 5)
        begin n_bad++; $display("FAIL sweep_%0d a=%h b=%h s=%b acc=%b: got %h/%b lat %0d want %h/%b lat 5",
                                i, av, bv, sg, ac, r, ov, lat, er, eo); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL sweep_release_%0d: out_valid=%b want 0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_accumulate();
    test_backpressure();
    test_reset_midbusy();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
